pattern_det_arb: RTL and testbench
==================================

PATTERN_DET_ARB -- requirements
Module: pattern_det_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one pattern_det instance.
REQ-002 SHALL have parameter BURST_LEN, default 16, maximum valid beats per grant.
REQ-003 SHALL have parameter DET_LAT, default 1, cycles from a detector input beat to its pattern output.
REQ-004 SHALL have parameter CNT_W, default 16, width of each per-requester match counter.
REQ-005 SHALL have ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; asynchronous, active-high.
- req_i  input  NUM_REQ  per-requester request level.
- d_i  input  NUM_REQ  per-requester serial data bit.
- valid_i  input  NUM_REQ  per-requester beat valid.
- gnt_o  output  NUM_REQ  one-hot grant.
- det_rst_o  output  1  detector reset.
- det_d_o  output  1  detector data.
- det_valid_o  output  1  detector valid.
- det_pattern_i  input  1  detector match pulse.
- cnt_sel_i  input  $clog2(NUM_REQ)  counter read select.
- cnt_o  output  CNT_W  selected counter value, combinational.
- busy_o  output  1  high in any state other than IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, FLUSH, STREAM, DRAIN.
REQ-007 IDLE: if any req_i bit is high, grant the round-robin winner; gnt_o registered, next state FLUSH.
REQ-008 Round-robin priority SHALL start at the index after the last owner; after reset, index 0 has highest priority.
REQ-009 FLUSH SHALL last exactly 1 cycle with det_rst_o=1 and det_valid_o=0, then enter STREAM.
REQ-010 STREAM: det_d_o=d_i[owner], det_valid_o=valid_i[owner], same cycle (combinational mux); non-owner inputs ignored.
REQ-011 STREAM SHALL count owner valid beats; on the BURST_LEN-th beat, or on a cycle where req_i[owner]=0, the next state is DRAIN.
REQ-012 A req_i[owner] drop and the BURST_LEN-th beat in the same cycle SHALL forward that beat, then enter DRAIN.
REQ-013 DRAIN SHALL hold det_valid_o=0 for exactly DET_LAT cycles, keep gnt_o, then go to IDLE with gnt_o=0.
REQ-014 A cycle with det_pattern_i=1 in STREAM or DRAIN SHALL increment the owner counter by 1; det_pattern_i is ignored in IDLE and FLUSH.
REQ-015 Counters SHALL saturate at 2^CNT_W-1.
REQ-016 Requesters other than the owner SHALL never be granted before DRAIN completes; gnt_o is never multi-hot.
REQ-017 The minimum gap between consecutive grants SHALL be 1 IDLE cycle.

Reset
REQ-018 While rst=1: state IDLE, gnt_o=0, det_rst_o=1, det_valid_o=0, det_d_o=0, busy_o=0, all counters 0, RR pointer 0.
REQ-019 Reset asserted mid-burst SHALL abort the burst immediately; no counter update in that cycle.

Configuration
REQ-020 With PATTERN_DET_ARB_CNT_CLR_EN defined, the block SHALL add input cnt_clr_i (1 bit), which zeroes the counter addressed by cnt_sel_i on the next edge; on a simultaneous increment, clear wins.
REQ-021 Without PATTERN_DET_ARB_CNT_CLR_EN, port cnt_clr_i SHALL not exist and counters SHALL clear only on reset.

Structure
REQ-022 Package pattern_det_arb_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-023 Sub-module rr_arbiter (req vector, pointer in, one-hot grant out, combinational) SHALL implement the priority selection.

Verification
REQ-024 Scenario 1: req_i=4'b0001, 16 valid beats carrying the pattern twice -> gnt_o=0001, 1 det_rst_o pulse, 16 det_valid_o beats, cnt[0]=2, busy_o low 1+DET_LAT cycles after the last beat.
REQ-025 Scenario 2: req_i=4'b1111 held -> grants in order 0001, 0010, 0100, 1000, 0001, each lasting 1+16+DET_LAT cycles.
REQ-026 Scenario 3: req 2 drops after 5 beats -> DRAIN entered after beat 5, a match pulse during DRAIN is credited to cnt[2].
REQ-027 Scenario 4: rst pulsed in STREAM after beat 7 -> all outputs take reset values the same cycle, counters 0, next grant goes to req 0.
REQ-028 Scenario 5: CNT_W=4, 20 matches on req 1 -> cnt[1]=15.
REQ-029 Scenario 6 (PATTERN_DET_ARB_CNT_CLR_EN): cnt_clr_i with cnt_sel_i=1, coincident with a match on owner 1 -> cnt[1]=0.

Source files
------------

// File: rtl/pattern_det_arb_pkg.sv
// Shared types and default parameters for the pattern detector arbiter.
package pattern_det_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_BURST_LEN = 16;
  localparam int DEF_DET_LAT   = 1;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/pattern_det_arb_rr.sv
// Combinational round-robin pick: ptr names the highest-priority index, priority wraps upward.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt
);

  logic [W-1:0] idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(ptr) + i) % N);
      if (req[idx]) begin
        gnt = N'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/pattern_det_arb.sv
// Shares one serial pattern detector among NUM_REQ requesters in round-robin bursts.
// Define PATTERN_DET_ARB_CNT_CLR_EN to add cnt_clr_i (clears the counter chosen by cnt_sel_i).
module pattern_det_arb
  import pattern_det_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int DET_LAT   = DEF_DET_LAT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         d_i,
  input  logic [NUM_REQ-1:0]         valid_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       det_rst_o,
  output logic                       det_d_o,
  output logic                       det_valid_o,
  input  logic                       det_pattern_i,
  input  logic [$clog2(NUM_REQ)-1:0] cnt_sel_i,
`ifdef PATTERN_DET_ARB_CNT_CLR_EN
  input  logic                       cnt_clr_i,
`endif
  output logic [CNT_W-1:0]           cnt_o,
  output logic                       busy_o,
  output state_t                     state_o
);

  localparam int SEL_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int LAT_W  = $clog2(DET_LAT + 1);

  state_t             state_q;
  logic [NUM_REQ-1:0] win;
  logic [SEL_W-1:0]   win_idx;
  logic [SEL_W-1:0]   ptr_q;
  logic [SEL_W-1:0]   owner_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [LAT_W-1:0]   lat_q;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic               stream;
  logic               beat;
  logic               stream_end;
  logic               cnt_en;

  rr_arbiter #(.N(NUM_REQ), .W(SEL_W)) u_arb (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_idx = SEL_W'(i);
    end
  end

  // Detector link: a beat transfers on every STREAM cycle where the owner's valid
  // is high; there is no backpressure, so det_valid_o is a pure forwarded strobe.
  assign stream      = (state_q == STREAM);
  assign det_d_o     = stream & d_i[owner_q];
  assign det_valid_o = stream & valid_i[owner_q];
  assign beat        = det_valid_o;
  assign stream_end  = (beat && beat_q == BEAT_W'(BURST_LEN - 1)) || !req_i[owner_q];
  assign cnt_en      = det_pattern_i && (state_q == STREAM || state_q == DRAIN);
  assign busy_o      = (state_q != IDLE);
  assign state_o     = state_q;
  assign cnt_o       = cnt_q[cnt_sel_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_o     <= '0;
      det_rst_o <= 1'b1;
      ptr_q     <= '0;
      owner_q   <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          det_rst_o <= |req_i;
          if (|req_i) begin
            state_q <= FLUSH;
            gnt_o   <= win;
            owner_q <= win_idx;
            ptr_q   <= (win_idx == SEL_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          end
        end
        FLUSH: begin
          state_q   <= STREAM;
          det_rst_o <= 1'b0;
          beat_q    <= '0;
        end
        STREAM: begin
          if (beat) beat_q <= beat_q + 1'b1;
          if (stream_end) begin
            state_q <= DRAIN;
            lat_q   <= '0;
          end
        end
        DRAIN: begin
          if (lat_q == LAT_W'(DET_LAT - 1)) begin
            state_q <= IDLE;
            gnt_o   <= '0;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Matches late by up to DET_LAT cycles still belong to the owner, hence DRAIN counts too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      if (cnt_en && cnt_q[owner_q] != {CNT_W{1'b1}}) begin
        cnt_q[owner_q] <= cnt_q[owner_q] + 1'b1;
      end
`ifdef PATTERN_DET_ARB_CNT_CLR_EN
      if (cnt_clr_i) cnt_q[cnt_sel_i] <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_pattern_det_arb.sv
// Bench for pattern_det_arb: directed scenarios plus random traffic against a cycle-age model.
module tb_pattern_det_arb;
  import pattern_det_arb_pkg::*;

  localparam int N    = 4;
  localparam int BL   = 16;
  localparam int LAT  = 1;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, din, vld, gnt;
  logic          det_rst, det_d, det_valid, pat, busy, cnt_clr;
  logic [1:0]    sel;
  logic [CW-1:0] cnt;
  state_t        dut_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;
  bit s2_on    = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] prev_gnt = '0;
  int           glen = 0;

  // Model: a grant is a session measured in cycles since grant (age 0 = flush).
  int m_owner, m_age, m_end_age, m_beats, m_prio, m_after_rst;
  int m_cnt [N];

  always #5 clk = ~clk;

  pattern_det_arb #(.NUM_REQ(N), .BURST_LEN(BL), .DET_LAT(LAT), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .d_i           (din),
    .valid_i       (vld),
    .gnt_o         (gnt),
    .det_rst_o     (det_rst),
    .det_d_o       (det_d),
    .det_valid_o   (det_valid),
    .det_pattern_i (pat),
    .cnt_sel_i     (sel),
`ifdef PATTERN_DET_ARB_CNT_CLR_EN
    .cnt_clr_i     (cnt_clr),
`endif
    .cnt_o         (cnt),
    .busy_o        (busy),
    .state_o       (dut_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_end_age = -1; m_beats = 0; m_prio = 0; m_after_rst = 1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step();
    int  w;
    bit  found;
    if (m_owner < 0) begin
      found = 0; w = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_prio + k) % N]) begin
          found = 1;
          w = (m_prio + k) % N;
        end
      end
      if (found) begin
        m_owner = w; m_age = 0; m_end_age = -1; m_beats = 0; m_prio = (w + 1) % N;
      end
    end else begin
      if (m_age >= 1 && pat && m_cnt[m_owner] < CMAX) m_cnt[m_owner]++;
      if (m_age >= 1 && m_end_age < 0) begin
        if (vld[m_owner]) m_beats++;
        if (m_beats == BL || !req[m_owner]) m_end_age = m_age;
      end
      m_age++;
      if (m_end_age >= 0 && m_age - m_end_age > LAT) m_owner = -1;
    end
`ifdef PATTERN_DET_ARB_CNT_CLR_EN
    if (cnt_clr) m_cnt[sel] = 0;
`endif
    m_after_rst = 0;
  endtask

  // Per-cycle compare against the model, then advance the model with the inputs the DUT will sample.
  always @(negedge clk) begin
    logic [N-1:0] e_gnt;
    logic         e_busy, e_rst, e_valid, e_d;
    state_t       e_state;
    if (chk_on) begin
      if (rst) model_reset();
      e_gnt = '0; e_busy = 0; e_rst = (m_after_rst != 0); e_valid = 0; e_d = 0; e_state = IDLE;
      if (m_owner >= 0) begin
        e_gnt[m_owner] = 1'b1;
        e_busy = 1;
        if (m_age == 0) begin
          e_rst = 1; e_state = FLUSH;
        end else if (m_end_age < 0) begin
          e_state = STREAM; e_valid = vld[m_owner]; e_d = din[m_owner];
        end else begin
          e_state = DRAIN;
        end
      end
      check("gnt", gnt, e_gnt);
      check("busy", busy, e_busy);
      check("det_rst", det_rst, e_rst);
      check("det_valid", det_valid, e_valid);
      check("det_d", det_d, e_d);
      check("state", dut_state, e_state);
      check("cnt", cnt, m_cnt[sel]);
      if (!rst) model_step();
      if (gnt != 0 && prev_gnt == 0) begin
        glen = 0;
        if (s2_on && exp_q.size() > 0) check("s2_order", gnt, exp_q.pop_front());
      end
      if (gnt != 0) glen++;
      if (gnt == 0 && prev_gnt != 0 && s2_on) check("s2_len", glen, 1 + BL + LAT);
      prev_gnt = gnt;
    end
  end

  task automatic do_reset();
    rst = 1; req = '0; vld = '0; din = '0; pat = 0; cnt_clr = 0;
    chk_on = 1;
    settle();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_det_rst", det_rst, 1);
    check("rst_det_valid", det_valid, 0);
    check("rst_det_d", det_d, 0);
    check("rst_cnt", cnt, 0);
    tick(); tick();
    rst = 0;
    tick(); tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    int waited;
    rst = 0; req = '0; din = '0; vld = '0; pat = 0; sel = '0; cnt_clr = 0;
    tick();
    do_reset();

    // Scenario 1: single requester, full burst, two matches, req drop on the last beat.
    sel = 0; req = 4'b0001; vld = '1;
    tick();
    settle();
    check("s1_gnt", gnt, 4'b0001);
    check("s1_flush_rst", det_rst, 1);
    check("s1_flush_valid", det_valid, 0);
    for (int b = 1; b <= BL; b++) begin
      tick();
      din = 4'($urandom);
      pat = (b == 4 || b == 11);
      if (b == BL) req = '0;
      settle();
      if (b == 1) check("s1_rst_low", det_rst, 0);
      if (b == BL) check("s1_last_fwd", det_valid, 1);
    end
    tick();
    pat = 0; vld = '0;
    settle();
    check("s1_drain_valid", det_valid, 0);
    check("s1_drain_gnt", gnt, 4'b0001);
    tick();
    settle();
    check("s1_idle_busy", busy, 0);
    check("s1_cnt0", cnt, 2);

    // Scenario 2: all requesting, rotation and burst length.
    do_reset();
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    s2_on = 1; req = '1; vld = '1;
    waited = 0;
    while ((exp_q.size() > 0 || gnt != 0) && waited < 200) begin
      tick();
      waited++;
    end
    check("s2_timeout", (waited < 200), 1);
    req = '0;
    tick();
    s2_on = 0;
    wait_idle();

    // Scenario 3: requester 2 drops with beat 5, match during drain is credited.
    do_reset();
    sel = 2; req = 4'b0100; vld = '1;
    tick();
    for (int b = 1; b <= 5; b++) begin
      tick();
      if (b == 5) req = '0;
      settle();
      if (b == 5) check("s3_beat5_fwd", det_valid, 1);
    end
    tick();
    pat = 1;
    settle();
    check("s3_drain_valid", det_valid, 0);
    check("s3_drain_gnt", gnt, 4'b0100);
    tick();
    pat = 0;
    settle();
    check("s3_busy", busy, 0);
    check("s3_cnt2", cnt, 1);

    // Scenario 4: reset after beat 7 of requester 1, then 0 wins over 2.
    do_reset();
    sel = 1; req = 4'b0010; vld = '1; pat = 1;
    tick();
    for (int b = 1; b <= 7; b++) tick();
    tick();
    settle();
    check("s4_cnt_before", cnt, 7);
    do_reset();
    sel = 1;
    settle();
    check("s4_cnt_cleared", cnt, 0);
    req = 4'b0101;
    tick();
    settle();
    check("s4_next_gnt", gnt, 4'b0001);
    req = '0;
    wait_idle();

    // Scenario 5: saturation of requester 1's counter.
    do_reset();
    sel = 1; req = 4'b0010; vld = '1; pat = 1;
    tick();
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 9) begin
        settle();
        check("s5_cnt_mid", cnt, 8);
      end
    end
    req = '0; pat = 0;
    wait_idle();
    settle();
    check("s5_cnt_sat", cnt, CMAX);

`ifdef PATTERN_DET_ARB_CNT_CLR_EN
    // Scenario 6: clear coincident with a match on owner 1.
    do_reset();
    sel = 1; req = 4'b0010; vld = '1; pat = 1;
    tick();
    repeat (4) tick();
    settle();
    check("s6_cnt_pre", cnt, 3);
    cnt_clr = 1;
    tick();
    cnt_clr = 0; pat = 0;
    settle();
    check("s6_cnt_clr", cnt, 0);
    req = '0;
    wait_idle();
`endif

    // Random traffic: sticky request levels, sparse matches, rare resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        continue;
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
        vld[i] = ($urandom_range(0, 3) != 0);
      end
      din = 4'($urandom);
      pat = ($urandom_range(0, 9) == 0);
      sel = 2'($urandom);
`ifdef PATTERN_DET_ARB_CNT_CLR_EN
      cnt_clr = ($urandom_range(0, 49) == 0);
`endif
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
